button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Debounces a raw mechanical button/switch input and produces a clean level.
- Sits directly upstream of the team's edge-detect one-shot; `sigOut` drives that block's `sigIn`.
- Provides an input synchronizer, a stability counter and a 4-state FSM.
- Also emits registered single-cycle rise/fall strobes for consumers that do not instantiate the one-shot.

Parameters:
- SYNC_STAGES, 2: flops in the input synchronizer chain; legal range >= 2.
- DEBOUNCE_CYCLES, 50000: consecutive stable synced cycles required to accept a new level; legal range >= 1.
- CNT_WIDTH, 16: stability counter width; must satisfy 2^CNT_WIDTH >= DEBOUNCE_CYCLES.
- Elaboration error if any of the three constraints is violated.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rstN  input  1  synchronous, active-low reset.
- sigIn  input  1  raw asynchronous button level.
- sigOut  output  1  debounced level (registered).
- risePulse  output  1  one-cycle strobe when sigOut goes 0->1 (registered).
- fallPulse  output  1  one-cycle strobe when sigOut goes 1->0 (registered).

Behaviour:
- Reset (rstN low at a rising edge):
  - Synchronizer flops, counter, sigOut, risePulse and fallPulse all go to 0.
  - State goes to STABLE_LOW.
  - Reset asserted mid-debounce abandons the pending transition; no pulse is emitted.
- Synchronizer:
  - syncd = last flop of a SYNC_STAGES-deep shift chain clocked from sigIn.
  - Only syncd feeds the FSM.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
  - STABLE_LOW: if syncd=1, go to WAIT_HIGH and set cnt=0; otherwise hold.
  - WAIT_HIGH, syncd=0: return to STABLE_LOW, cnt=0, no output change (glitch rejected).
  - WAIT_HIGH, syncd=1 and cnt==DEBOUNCE_CYCLES-1: go to STABLE_HIGH, sigOut<=1, risePulse<=1, cnt=0.
  - WAIT_HIGH, syncd=1 otherwise: cnt<=cnt+1.
  - STABLE_HIGH and WAIT_LOW mirror the above with polarity inverted; the accepting edge drives fallPulse.
- Counter:
  - Counts only in WAIT states and never wraps (terminal compare precedes increment).
  - Held at 0 in STABLE states.
- Revert on the terminal edge: if syncd reverts on the same edge where cnt==DEBOUNCE_CYCLES-1, the revert wins. The FSM returns to the stable state and emits no pulse.
- Latency: number the first rising edge that samples a new sigIn level as edge 1. sigOut changes after edge SYNC_STAGES+DEBOUNCE_CYCLES+1, provided sigIn stays stable throughout.
- Pulses:
  - risePulse/fallPulse are high for exactly the one cycle in which sigOut first shows its new value.
  - They are never high simultaneously and otherwise stay 0.
- A sigIn pulse shorter than DEBOUNCE_CYCLES synced cycles never changes sigOut.
- An input held constant never produces pulses.

Decomposition:
- Shared package: state enum (2-bit encoding STABLE_LOW=0, WAIT_HIGH=1, STABLE_HIGH=2, WAIT_LOW=3), default parameter constants, and a clog2 function for the CNT_WIDTH check.
- One natural sub-module: sync_chain (parameterised SYNC_STAGES flop chain with synchronous active-low reset, 1-bit in/out). It is reusable as the codebase's standard dual-flop synchronizer.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: drive rstN=0 for 3 edges with sigIn=1 -> sigOut, risePulse and fallPulse = 0; state STABLE_LOW after release.
- Clean press: sigIn 0->1 sampled at edge 1 and held -> sigOut=1 after edge 7; risePulse=1 only in the cycle after edge 7.
- Bounce: sigIn=1 for 3 edges, then 0, then 1 held -> no pulse during bounce; counter restarts; sigOut=1 exactly 7 edges after the final 0->1 sample.
- Release: with sigOut=1, sigIn 1->0 held -> sigOut=0 after edge 7; fallPulse one cycle; risePulse stays 0.
- Terminal-edge revert: syncd returns to 0 on the edge where cnt==3 -> sigOut stays 0, no risePulse, state STABLE_LOW.
- Reset mid-debounce: rstN=0 while in WAIT_HIGH with cnt=2 -> all outputs 0, no pulse.
  - After release, with sigIn still 1, sigOut=1 seven edges after the first post-reset sample.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the button debouncer: FSM state encoding,
// default parameter values and the width helper used for elaboration checks.
package button_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_CNT_WIDTH       = 16;

    // Bits needed to count from 0 to value-1.
    function automatic int clog2_f(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; the default depth of
// two is the standard dual-flop synchronizer.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button level: synchronizer, stability counter and a
// four-state FSM, with registered rise/fall strobes alongside the clean level.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rstN,
    input  logic sigIn,
    output logic sigOut,
    output logic risePulse,
    output logic fallPulse
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_debouncer: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH < clog2_f(DEBOUNCE_CYCLES)) begin : g_bad_width
        $error("button_debouncer: CNT_WIDTH too narrow for DEBOUNCE_CYCLES");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 syncd;
    db_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sig_q, sig_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_n_i(rstN),
        .d_i    (sigIn),
        .q_o    (syncd)
    );

    // A revert on the terminal-count edge is tested first, so it always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        sig_d   = sig_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (syncd) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!syncd) begin
                    state_d = STABLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    sig_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!syncd) state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (syncd) begin
                    state_d = STABLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    sig_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = STABLE_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            sig_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sigOut    = sig_q;
    assign risePulse = rise_q;
    assign fallPulse = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
// stimulus queues expected pulses, a negedge monitor checks every cycle.
module tb_button_debouncer;
    import button_debouncer_pkg::*;

    localparam int LAT = 7;

    logic clk = 1'b0;
    logic rstN;
    logic sigIn;
    logic sigOut;
    logic risePulse;
    logic fallPulse;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rst_edge = 1'b1;
    bit mon_en   = 1'b0;
    bit exp_lvl  = 1'b0;

    typedef struct {
        bit rise;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    button_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .sigIn    (sigIn),
        .sigOut   (sigOut),
        .risePulse(risePulse),
        .fallPulse(fallPulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !rstN;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_pulse(input bit rise);
        exp_t e;
        e.rise = rise;
        e.cyc  = cyc + LAT;
        exp_q.push_back(e);
    endtask

    // Monitor: pulses and level must match the queued expectations exactly.
    always @(negedge clk) begin
        exp_t e;
        bit   er;
        bit   ef;
        if (mon_en) begin
            er = 1'b0;
            ef = 1'b0;
            if (rst_edge) exp_lvl = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("missed_pulse_cycle", cyc, e.cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e       = exp_q.pop_front();
                er      = e.rise;
                ef      = !e.rise;
                exp_lvl = e.rise;
            end
            check("risePulse", int'(risePulse), int'(er));
            check("fallPulse", int'(fallPulse), int'(ef));
            check("sigOut", int'(sigOut), int'(exp_lvl));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstN  = 1'b0;
        sigIn = 1'b1;
        step(3);
        check("reset_sigOut", int'(sigOut), 0);
        check("reset_risePulse", int'(risePulse), 0);
        check("reset_fallPulse", int'(fallPulse), 0);
        rstN   = 1'b1;
        sigIn  = 1'b0;
        mon_en = 1'b1;
        step(1);
        check("state_after_reset", int'(dut.state_q), int'(STABLE_LOW));
        step(5);

        // Clean press and clean release
        expect_pulse(1'b1);
        sigIn = 1'b1;
        step(12);
        expect_pulse(1'b0);
        sigIn = 1'b0;
        step(12);

        // Bounce on press: 3 high samples, 1 low, then held high
        sigIn = 1'b1;
        step(3);
        sigIn = 1'b0;
        step(1);
        expect_pulse(1'b1);
        sigIn = 1'b1;
        step(12);

        // Glitch low while high must not produce a fall
        sigIn = 1'b0;
        step(2);
        sigIn = 1'b1;
        step(10);
        check("glitch_low_state", int'(dut.state_q), int'(STABLE_HIGH));
        expect_pulse(1'b0);
        sigIn = 1'b0;
        step(12);

        // Revert on the terminal-count edge
        sigIn = 1'b1;
        step(4);
        sigIn = 1'b0;
        step(2);
        check("terminal_cnt", int'(dut.cnt_q), 3);
        check("terminal_state", int'(dut.state_q), int'(WAIT_HIGH));
        step(1);
        check("revert_state", int'(dut.state_q), int'(STABLE_LOW));
        check("revert_sigOut", int'(sigOut), 0);
        step(10);

        // Reset in the middle of a pending rise
        sigIn = 1'b1;
        step(5);
        check("mid_cnt", int'(dut.cnt_q), 2);
        check("mid_state", int'(dut.state_q), int'(WAIT_HIGH));
        rstN = 1'b0;
        step(2);
        check("midrst_sigOut", int'(sigOut), 0);
        check("midrst_risePulse", int'(risePulse), 0);
        check("midrst_cnt", int'(dut.cnt_q), 0);
        rstN = 1'b1;
        expect_pulse(1'b1);
        step(12);
        expect_pulse(1'b0);
        sigIn = 1'b0;
        step(12);

        check("pending_expectations", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
